// File: rtl/buffer_ctrl.sv
// Sequencing controller between the UART receiver, the FIFO buffer and the Morse encoder.
// Registers buffer writes, owns the read pointer and re-times reads around the buffer latency.
module buffer_ctrl #(
  parameter int unsigned RD_LATENCY = 3,
  parameter int unsigned ADDR_W     = 11
) (
  input  logic              i_clk_24,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_buf_rw,
  output logic [7:0]        o_buf_data,
  input  logic [ADDR_W-1:0] i_wr_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [6:0]        i_rd_data,
  output logic [6:0]        o_char,
  output logic              o_char_valid,
  input  logic              i_char_ready,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_reject
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StFetch   = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;

  localparam logic [3:0]        LatLast = 4'(RD_LATENCY);
  localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        cnt_inc;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_inc;
  logic [6:0]        char_q, char_d;
  logic              char_valid_q, char_valid_d;
  logic              buf_rw_q, buf_rw_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic              overflow_q, overflow_d;
  logic              reject_q, reject_d;
  logic              empty, full;

  assign wr_addr_inc = i_wr_addr + AddrOne;
  assign empty       = (rd_addr_q == i_wr_addr);
  assign full        = (wr_addr_inc == rd_addr_q);
  assign cnt_inc     = {1'b0, cnt_q} + 4'd1;

  // Bit 7 is checked first so a rejected byte never reports overflow.
  always_comb begin
    buf_rw_d   = 1'b0;
    buf_data_d = buf_data_q;
    overflow_d = 1'b0;
    reject_d   = 1'b0;
    if (i_rx_valid) begin
      if (i_rx_data[7]) begin
        reject_d = 1'b1;
      end else if (full) begin
        overflow_d = 1'b1;
      end else begin
        buf_rw_d   = 1'b1;
        buf_data_d = i_rx_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_addr_d    = rd_addr_q;
    char_d       = char_q;
    char_valid_d = char_valid_q;
    case (state_q)
      StIdle: begin
        char_valid_d = 1'b0;
        if (!empty && !buf_rw_q) begin
          state_d = StFetch;
          cnt_d   = 3'd0;
        end
      end
      StFetch: begin
        // The buffer drops its read address while writing, so the wait starts over.
        if (buf_rw_q) begin
          cnt_d = 3'd0;
        end else if (cnt_inc == LatLast) begin
          char_d       = i_rd_data;
          char_valid_d = 1'b1;
          state_d      = StPresent;
          cnt_d        = 3'd0;
        end else begin
          cnt_d = cnt_inc[2:0];
        end
      end
      StPresent: begin
        if (i_char_ready) begin
          char_valid_d = 1'b0;
          rd_addr_d    = rd_addr_q + AddrOne;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d      = StIdle;
        cnt_d        = 3'd0;
        char_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk_24) begin
    if (i_rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      rd_addr_q    <= '0;
      char_q       <= 7'd0;
      char_valid_q <= 1'b0;
      buf_rw_q     <= 1'b0;
      buf_data_q   <= 8'd0;
      overflow_q   <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_addr_q    <= rd_addr_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      buf_rw_q     <= buf_rw_d;
      buf_data_q   <= buf_data_d;
      overflow_q   <= overflow_d;
      reject_q     <= reject_d;
    end
  end

  assign o_buf_rw     = buf_rw_q;
  assign o_buf_data   = buf_data_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_char       = char_q;
  assign o_char_valid = char_valid_q;
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_overflow   = overflow_q;
  assign o_reject     = reject_q;

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl with a behavioural model of the FIFO buffer and its read latency.
module tb_buffer_ctrl;

  localparam int unsigned RdLat = 3;
  localparam int unsigned AddrW = 11;

  logic             clk;
  logic             rst;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             buf_rw;
  logic [7:0]       buf_data;
  logic [AddrW-1:0] wr_addr;
  logic [AddrW-1:0] rd_addr;
  logic [6:0]       rd_data;
  logic [6:0]       chr;
  logic             chr_valid;
  logic             chr_ready;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             reject;

  int errors = 0;
  int checks = 0;

  buffer_ctrl #(
    .RD_LATENCY (RdLat),
    .ADDR_W     (AddrW)
  ) dut (
    .i_clk_24     (clk),
    .i_rst        (rst),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_buf_rw     (buf_rw),
    .o_buf_data   (buf_data),
    .i_wr_addr    (wr_addr),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_char       (chr),
    .o_char_valid (chr_valid),
    .i_char_ready (chr_ready),
    .o_empty      (empty),
    .o_full       (full),
    .o_overflow   (overflow),
    .o_reject     (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: data is only valid once the address has been stable with no write.
  logic [6:0]       mem [2048];
  logic [AddrW-1:0] last_rd;
  int               stab;

  always @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      last_rd <= '0;
      stab    <= 0;
    end else begin
      if (buf_rw) begin
        mem[wr_addr] <= buf_data[6:0];
        wr_addr      <= wr_addr + 11'd1;
      end
      if (buf_rw || rd_addr != last_rd) stab <= 0;
      else if (stab < 100) stab <= stab + 1;
      last_rd <= rd_addr;
    end
  end

  assign rd_data = (stab >= int'(RdLat) - 1) ? mem[rd_addr] : 7'h7F;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!chr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    if (!chr_valid) check(tag, 32'(chr_valid), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic handshake();
    chr_ready = 1'b1;
    tick();
    chr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int bad;
    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'd0;
    chr_ready = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_valid", 32'(chr_valid), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_buf_rw", 32'(buf_rw), 32'd0);

    // Single byte: rx at N, write at N+1, valid at N+6
    repeat (4) tick();
    send(8'h53);
    check("single_rw", 32'(buf_rw), 32'd1);
    check("single_data", 32'(buf_data), 32'h53);
    tick();
    check("single_empty_fall", 32'(empty), 32'd0);
    repeat (3) tick();
    check("single_valid_early", 32'(chr_valid), 32'd0);
    tick();
    check("single_valid", 32'(chr_valid), 32'd1);
    check("single_char", 32'(chr), 32'h53);
    repeat (4) tick();
    handshake();
    check("single_rd_addr", 32'(rd_addr), 32'd1);
    check("single_empty", 32'(empty), 32'd1);
    check("single_valid_drop", 32'(chr_valid), 32'd0);

    // Write two cycles into FETCH restarts the wait
    send(8'h41);
    repeat (3) tick();
    send(8'h42);
    check("wdf_write", 32'(buf_rw), 32'd1);
    tick();
    check("wdf_no_early1", 32'(chr_valid), 32'd0);
    repeat (2) tick();
    check("wdf_no_early3", 32'(chr_valid), 32'd0);
    tick();
    check("wdf_valid", 32'(chr_valid), 32'd1);
    check("wdf_char", 32'(chr), 32'h41);
    handshake();
    wait_valid("wdf_second_timeout", 20);
    check("wdf_second", 32'(chr), 32'h42);
    handshake();

    // SOS burst with backpressure
    do_reset();
    send(8'h53);
    send(8'h4F);
    send(8'h53);
    wait_valid("sos_timeout", 20);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(chr_valid === 1'b1 && chr === 7'h53)) bad++;
      tick();
    end
    check("sos_held", 32'(bad), 32'd0);
    handshake();
    wait_valid("sos_o_timeout", 20);
    check("sos_o", 32'(chr), 32'h4F);
    handshake();
    wait_valid("sos_s2_timeout", 20);
    check("sos_s2", 32'(chr), 32'h53);
    handshake();
    check("sos_rd_addr", 32'(rd_addr), 32'd3);
    check("sos_empty", 32'(empty), 32'd1);

    // Reject on bit 7
    send(8'hC1);
    check("rej_pulse", 32'(reject), 32'd1);
    check("rej_no_write", 32'(buf_rw), 32'd0);
    tick();
    check("rej_one_cycle", 32'(reject), 32'd0);
    check("rej_empty", 32'(empty), 32'd1);

    // Fill to 2047 entries, spaced so each write lands before the next full test
    do_reset();
    for (int i = 0; i < 2047; i++) begin
      send(8'(i % 127));
      tick();
    end
    repeat (5) tick();
    check("full_set", 32'(full), 32'd1);
    send(8'h11);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_no_write", 32'(buf_rw), 32'd0);
    tick();
    check("ovf_one_cycle", 32'(overflow), 32'd0);
    send(8'h80);
    check("full_rej_pulse", 32'(reject), 32'd1);
    check("full_rej_no_ovf", 32'(overflow), 32'd0);
    tick();
    bad = 0;
    for (int i = 0; i < 2047; i++) begin
      wait_valid("drain_timeout", 20);
      if (chr !== 7'(i % 127) || rd_addr !== 11'(i)) bad++;
      handshake();
    end
    check("drain_order", 32'(bad), 32'd0);
    check("drain_rd_addr", 32'(rd_addr), 32'd2047);
    check("drain_empty", 32'(empty), 32'd1);
    send(8'h2A);
    wait_valid("wrap_timeout", 20);
    check("wrap_char", 32'(chr), 32'h2A);
    handshake();
    check("wrap_rd_addr", 32'(rd_addr), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset while presenting; a byte arriving in the reset cycle is dropped
    send(8'h44);
    wait_valid("rmp_timeout", 20);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h33;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("rmp_valid", 32'(chr_valid), 32'd0);
    check("rmp_char", 32'(chr), 32'd0);
    check("rmp_rd_addr", 32'(rd_addr), 32'd0);
    check("rmp_buf_rw", 32'(buf_rw), 32'd0);
    check("rmp_buf_data", 32'(buf_data), 32'd0);
    check("rmp_flags", 32'({overflow, reject}), 32'd0);
    check("rmp_empty", 32'(empty), 32'd1);
    tick();
    send(8'h5A);
    wait_valid("rmp_after_timeout", 20);
    check("rmp_after_char", 32'(chr), 32'h5A);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
